// File: rtl/seq_sub_pkg.sv
// Shared definitions for the sequential slice-serial 32-bit subtractor.
package seq_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W_DEF = 8;
  localparam int NUM_SLICES  = 32 / SLICE_W_DEF;

  // Signed overflow of a - b: operand signs differ and the result sign left the minuend's.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/sub_slice.sv
// Purely combinational SLICE_W-bit ripple-borrow subtractor: d = x - y - bi.
module sub_slice #(
  parameter int SLICE_W = 8
) (
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               bi,
  output logic [SLICE_W-1:0] d,
  output logic               bo
);

  logic [SLICE_W:0] chain_s;

  // Bit-serial borrow chain; bit i borrows when x<y, or x==y with a borrow pending
  always_comb begin
    chain_s    = '0;
    d          = '0;
    chain_s[0] = bi;
    for (int i = 0; i < SLICE_W; i++) begin
      d[i]         = x[i] ^ y[i] ^ chain_s[i];
      chain_s[i+1] = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & chain_s[i]);
    end
    bo = chain_s[SLICE_W];
  end

endmodule

// File: rtl/seq_sub_32bit.sv
// Sequential 32-bit subtractor: one SLICE_W-bit slice per CALC cycle, LSB first,
// through a single shared sub_slice instance.
module seq_sub_32bit
  import seq_sub_pkg::*;
#(
  parameter int SLICE_W = SLICE_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bin,
  output logic [31:0] diff,
  output logic        bout,
  output logic        ovf,
  output logic        busy,
  output logic        done
);

  localparam int NUM_SL = 32 / SLICE_W;
  localparam int CNT_W  = (NUM_SL > 1) ? $clog2(NUM_SL) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SL - 1);

  state_t             state_r;
  state_t             next_state_s;
  logic [31:0]        a_r;
  logic [31:0]        b_r;
  logic               bin_r;
  logic               borrow_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [31:0]        diff_r;
  logic               bout_r;
  logic               ovf_r;
  logic               busy_r;
  logic               done_r;

  int                 slice_base_s;
  logic               last_s;
  logic [SLICE_W-1:0] x_s;
  logic [SLICE_W-1:0] y_s;
  logic               bi_s;
  logic [SLICE_W-1:0] d_s;
  logic               bo_s;

  // Current slice operands; slice 0 takes the latched borrow-in
  always_comb begin
    slice_base_s = int'(cnt_r) * SLICE_W;
    last_s       = (cnt_r == LAST_CNT);
    x_s          = a_r[slice_base_s +: SLICE_W];
    y_s          = b_r[slice_base_s +: SLICE_W];
    if (cnt_r == '0) begin
      bi_s = bin_r;
    end else begin
      bi_s = borrow_r;
    end
  end

  sub_slice #(
    .SLICE_W(SLICE_W)
  ) u_slice (
    .x  (x_s),
    .y  (y_s),
    .bi (bi_s),
    .d  (d_s),
    .bo (bo_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = CALC;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand latch, slice write-back and result/status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      bin_r    <= 1'b0;
      borrow_r <= 1'b0;
      cnt_r    <= '0;
      diff_r   <= 32'd0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            bin_r    <= bin;
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b1;
          end
        end
        CALC: begin
          diff_r[slice_base_s +: SLICE_W] <= d_s;
          borrow_r <= bo_s;
          if (last_s) begin
            bout_r <= bo_s;
            ovf_r  <= sub_ovf(a_r[31], b_r[31], d_s[SLICE_W-1]);
            done_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE:    busy_r <= 1'b0;
        default: busy_r <= 1'b0;
      endcase
    end
  end

  assign diff = diff_r;
  assign bout = bout_r;
  assign ovf  = ovf_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_seq_sub_32bit.sv
// Self-checking bench for seq_sub_32bit: directed corners, random operands,
// busy/hold behaviour, back-to-back starts and reset mid-operation.
module tb_seq_sub_32bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        bin;
  logic [31:0] diff;
  logic        bout;
  logic        ovf;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  seq_sub_32bit #(.SLICE_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .diff  (diff),
    .bout  (bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Reference: plain wide arithmetic; overflow means the true signed result leaves 32-bit range
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic mbin);
    longint unsigned ua;
    longint unsigned ub;
    longint          sd;
    logic [31:0]     md;
    logic            mbo;
    logic            mov;
    ua  = {32'd0, ma};
    ub  = {32'd0, mb};
    md  = 32'(ua - ub - longint'(mbin));
    mbo = (ua < ub + longint'(mbin));
    sd  = longint'($signed(ma)) - longint'($signed(mb)) - longint'(mbin);
    mov = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    return {md, mbo, mov};
  endfunction

  // Drives one start pulse, scrambles inputs after acceptance, waits (bounded) for done
  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic obin, output int lat);
    @(negedge clk);
    a = oa; b = ob; bin = obin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 32'hdeadbeef; b = 32'h12345678; bin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({diff, bout, ovf, busy, done} !== 36'd0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", {diff, bout, ovf, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] ta [4] = '{32'haab12fcd, 32'h00000000, 32'h80000000, 32'h00000005};
    logic [31:0] tb [4] = '{32'haaaabbbc, 32'h00000001, 32'h00000001, 32'h00000005};
    logic        tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [33:0] te [4] = '{{32'h00067411, 1'b0, 1'b0}, {32'hffffffff, 1'b1, 1'b0},
                            {32'h7fffffff, 1'b0, 1'b1}, {32'hffffffff, 1'b1, 1'b0}};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], tc[i], lat);
      total++;
      if (lat !== 5) begin
        bad++;
        $display("FAIL dir%0d_latency got=%0d exp=5", i, lat);
      end
      total++;
      if ({diff, bout, ovf} !== te[i]) begin
        bad++;
        $display("FAIL dir%0d_result got=%h/%b/%b exp=%h/%b/%b", i, diff, bout, ovf,
                 te[i][33:2], te[i][1], te[i][0]);
      end
      @(posedge clk); #1;
      total++;
      if ({done, busy} !== 2'b00) begin
        bad++;
        $display("FAIL dir%0d_pulse done/busy got=%b%b exp=00", i, done, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    logic [33:0] exp;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      ra = (i % 7 == 0) ? 32'h80000000 : $urandom;
      rb = (i % 5 == 0) ? ra : $urandom;
      rc = 1'($urandom_range(0, 1));
      exp = model(ra, rb, rc);
      do_op(ra, rb, rc, lat);
      total++;
      if (lat !== 5 || {diff, bout, ovf} !== exp) begin
        bad++;
        $display("FAIL rand%0d a=%h b=%h bin=%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=5", i, ra, rb, rc,
                 diff, bout, ovf, lat, exp[33:2], exp[1], exp[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_hold_and_busy();
    logic [33:0] exp;
    logic [33:0] held;
    int          lat;
    int          extra;
    held = {diff, bout, ovf};
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    total++;
    if ({diff, bout, ovf} !== held || busy !== 1'b0 || extra != 0) begin
      bad++;
      $display("FAIL idle_hold got=%h busy=%b dones=%0d exp=%h busy=0 dones=0", {diff, bout, ovf}, busy, extra, held);
    end
    // start kept high through CALC with changing operands must not disturb the operation
    exp = model(32'h0000_1000, 32'h0000_2000, 1'b1);
    @(negedge clk);
    a = 32'h0000_1000; b = 32'h0000_2000; bin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    repeat (3) begin
      a = $urandom; b = $urandom; bin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 5 || {diff, bout, ovf} !== exp) begin
      bad++;
      $display("FAIL busy_ignore got=%h lat=%0d exp=%h lat=5", {diff, bout, ovf}, lat, exp);
    end
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL busy_ignore_extra_done got=%0d exp=0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa [30];
    logic [31:0] ob [30];
    logic        oc [30];
    logic [33:0] exp;
    int          ndone;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      oa[k] = $urandom; ob[k] = $urandom; oc[k] = 1'($urandom_range(0, 1));
      @(negedge clk);
      a = oa[k]; b = ob[k]; bin = oc[k]; start = 1'b1;
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ndone++;
        total++;
        if (k % 6 != 4) begin
          bad++;
          $display("FAIL b2b_timing done at cycle=%0d exp=6n+4", k);
        end else begin
          exp = model(oa[k-4], ob[k-4], oc[k-4]);
          total++;
          if ({diff, bout, ovf} !== exp) begin
            bad++;
            $display("FAIL b2b_result cycle=%0d got=%h exp=%h", k, {diff, bout, ovf}, exp);
          end
        end
      end
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (ndone != 5) begin
      bad++;
      $display("FAIL b2b_count got=%0d exp=5", ndone);
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid_calc();
    logic [33:0] exp;
    int          lat;
    int          seen;
    do_op(32'haab12fcd, 32'haaaabbbc, 1'b0, lat);
    @(posedge clk); #1;
    @(negedge clk);
    a = 32'h0f0f0f0f; b = 32'h00000001; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++;
    if ({diff, bout, ovf, busy, done} !== 36'd0) begin
      bad++;
      $display("FAIL rst_mid_calc got=%h exp=0", {diff, bout, ovf, busy, done});
    end
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL rst_no_done got=%0d exp=0", seen);
    end
    exp = model(32'h12345678, 32'h87654321, 1'b1);
    do_op(32'h12345678, 32'h87654321, 1'b1, lat);
    total++;
    if (lat !== 5 || {diff, bout, ovf} !== exp) begin
      bad++;
      $display("FAIL rst_recover got=%h lat=%0d exp=%h lat=5", {diff, bout, ovf}, lat, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold_and_busy();
    test_back_to_back();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
